// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, x, y, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, x, y, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - sliced ripple add/subtract with one slice per pipeline stage
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_adder_if.slave  bus
);
    localparam int SW = (STAGES > 0) ? WIDTH / STAGES : 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % SW) != 0) || (SW * STAGES != WIDTH)) begin : g_bad_param
        $fatal(1, "pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             w_en;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_ye;
    logic             w_c0;

    // Subtraction is x + ~y + 1, so cin is overridden in subtract mode.
    assign w_ye = bus.sub ? ~bus.y : bus.y;
    assign w_c0 = bus.sub | bus.cin;

    // The whole pipeline advances together unless a held result is blocking the output.
    assign w_en         = !w_out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    // Stage k adds slice k; its register carries the finished lower slices
    // plus the still-unused upper operand slices of the same operation.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * SW;
        localparam int OW = (k + 1) * SW;

        logic [IW-1:0] w_xi;
        logic [IW-1:0] w_yi;
        logic          w_ci;
        logic          w_vi;
        logic [SW-1:0] w_slice;
        logic          w_co;
        logic [OW-1:0] w_sn;

        logic          r_v;
        logic          r_c;
        logic [OW-1:0] r_s;

        if (k == 0) begin : g_head
            assign w_xi = bus.x;
            assign w_yi = w_ye;
            assign w_ci = w_c0;
            assign w_vi = bus.in_valid;
            assign w_sn = w_slice;
        end else begin : g_body
            assign w_xi = g_stage[k-1].g_fwd.r_x;
            assign w_yi = g_stage[k-1].g_fwd.r_y;
            assign w_ci = g_stage[k-1].r_c;
            assign w_vi = g_stage[k-1].r_v;
            assign w_sn = {w_slice, g_stage[k-1].r_s};
        end

        assign {w_co, w_slice} = {1'b0, w_xi[SW-1:0]} + {1'b0, w_yi[SW-1:0]} + {{SW{1'b0}}, w_ci};

        // Capture this stage's valid, carry-out and accumulated result slices.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_vi;
                r_c <= w_co;
                r_s <= w_sn;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IW-SW-1:0] r_x;
            logic [IW-SW-1:0] r_y;

            // Delay the upper operand slices so they meet their carry in the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (w_en) begin
                    r_x <= w_xi[IW-1:SW];
                    r_y <= w_yi[IW-1:SW];
                end
            end
        end else begin : g_last
            logic r_o;

            // Signed overflow: like-signed operands producing a result of the other sign.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_o <= 1'b0;
                end else if (w_en) begin
                    r_o <= (w_xi[IW-1] == w_yi[IW-1]) && (w_slice[SW-1] != w_xi[IW-1]);
                end
            end
        end
    end

    assign w_out_valid   = g_stage[STAGES-1].r_v;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = g_stage[STAGES-1].r_s;
    assign bus.cout      = g_stage[STAGES-1].r_c;
    assign bus.ovf       = g_stage[STAGES-1].g_last.r_o;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder across several configurations
module tb_pipelined_adder;
    localparam int NCFG = 5;
    localparam int NOPS = 1000;
    localparam int NTAB = 13;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    bit   sweep_go = 0;
    int   pend [NCFG];
    logic [33:0] exp_main;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    vec_t tab [NTAB];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_w(input int i);
        case (i)
            0: return 16;
            1: return 4;
            2: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0: return 4;
            1: return 1;
            2: return 2;
            3: return 8;
            default: return 32;
        endcase
    endfunction

    // Reference: exact integer arithmetic, then range tests for carry and signed overflow.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input logic sb);
        longint m;
        longint ua;
        longint ub;
        longint sa;
        longint sbv;
        longint ur;
        longint ideal;
        logic   co;
        logic   ov;
        m   = longint'(1) << w;
        ua  = longint'(a) & (m - 1);
        ub  = longint'(b) & (m - 1);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbv = (ub >= m / 2) ? ub - m : ub;
        if (sb) begin
            ur    = ua - ub;
            co    = (ua >= ub);
            ideal = sa - sbv;
        end else begin
            ur    = ua + ub + longint'(ci);
            co    = (ur >= m);
            ideal = sa + sbv + longint'(ci);
        end
        ov = (ideal >= m / 2) || (ideal < -(m / 2));
        ur = ur & (m - 1);
        return {ov, co, 32'(ur)};
    endfunction

    task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", g, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = cfg_w(g);
        localparam int S = cfg_s(g);
        localparam bit EXT = (g == 0);

        pipelined_adder_if #(.WIDTH(W)) bus ();

        pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        logic [33:0] q_exp [$];
        int          q_acc [$];
        int          q_stl [$];
        int          cyc = 0;
        int          stalls = 0;
        bit          head_new = 1;
        bit          prev_stall = 0;
        logic [W-1:0] prev_sum = '0;
        logic [33:0] e;

        // Scoreboard: push on accept, pop/compare on output transfer, check hold and latency.
        initial begin
            pend[g] = 0;
            forever begin
                @(negedge clk);
                #2;
                if (!rst_n) begin
                    q_exp.delete();
                    q_acc.delete();
                    q_stl.delete();
                    head_new   = 1;
                    prev_stall = 0;
                end else begin
                    chk(g, "in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
                    if (prev_stall) begin
                        chk(g, "hold_valid", 64'(bus.out_valid), 64'(1));
                        chk(g, "hold_sum", 64'(bus.sum), 64'(prev_sum));
                    end
                    if (bus.out_valid) begin
                        if (q_exp.size() == 0) begin
                            chk(g, "spurious_valid", 64'(bus.out_valid), 64'(0));
                        end else begin
                            if (head_new) begin
                                chk(g, "latency", 64'(cyc - q_acc[0]), 64'(S + stalls - q_stl[0]));
                                head_new = 0;
                            end
                            if (bus.out_ready) begin
                                e = q_exp.pop_front();
                                void'(q_acc.pop_front());
                                void'(q_stl.pop_front());
                                chk(g, "sum", 64'(bus.sum), 64'(e[31:0]));
                                chk(g, "cout", 64'(bus.cout), 64'(e[32]));
                                chk(g, "ovf", 64'(bus.ovf), 64'(e[33]));
                                head_new = 1;
                            end
                        end
                    end
                    if (bus.in_valid && bus.in_ready) begin
                        if (EXT) e = exp_main;
                        else     e = ref_add(W, 32'(bus.x), 32'(bus.y), bus.cin, bus.sub);
                        q_exp.push_back(e);
                        q_acc.push_back(cyc);
                        q_stl.push_back(stalls);
                    end
                    prev_stall = bus.out_valid && !bus.out_ready;
                    prev_sum   = bus.sum;
                    if (prev_stall) stalls++;
                end
                pend[g] = q_exp.size();
                cyc++;
            end
        end

        if (g > 0) begin : g_rand
            int n_sent = 0;
            // Random operands, modes and output backpressure once the directed tests are done.
            initial begin
                bus.in_valid  = 1'b0;
                bus.x         = '0;
                bus.y         = '0;
                bus.cin       = 1'b0;
                bus.sub       = 1'b0;
                bus.out_ready = 1'b1;
                wait (sweep_go);
                for (int t = 0; t < 20000; t++) begin
                    if (n_sent == NOPS && pend[g] == 0) break;
                    @(negedge clk);
                    bus.in_valid  = (n_sent < NOPS) && ($urandom_range(0, 3) != 0);
                    bus.x         = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom());
                    bus.y         = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom());
                    bus.cin       = 1'($urandom());
                    bus.sub       = 1'($urandom());
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    if (bus.in_valid && bus.in_ready) n_sent++;
                end
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
                chk(g, "sweep_sent", 64'(n_sent), 64'(NOPS));
                chk(g, "sweep_drained", 64'(pend[g]), 64'(0));
                n_done++;
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                        input logic [33:0] e);
        @(negedge clk);
        exp_main              = e;
        g_cfg[0].bus.x        = a;
        g_cfg[0].bus.y        = b;
        g_cfg[0].bus.cin      = ci;
        g_cfg[0].bus.sub      = sb;
        g_cfg[0].bus.in_valid = 1'b1;
        #1;
        for (int t = 0; t < 64 && !g_cfg[0].bus.in_ready; t++) begin
            @(negedge clk);
            #1;
        end
        chk(0, "accepted", 64'(g_cfg[0].bus.in_ready), 64'(1));
    endtask

    task automatic idle();
        @(negedge clk);
        g_cfg[0].bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            #3;
            if (pend[0] == 0 && !g_cfg[0].bus.out_valid) break;
        end
        chk(0, "drained", 64'(pend[0]), 64'(0));
    endtask

    function automatic logic [33:0] m16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                        input logic sb);
        return ref_add(16, {16'h0, a}, {16'h0, b}, ci, sb);
    endfunction

    initial begin
        rst_n                  = 1'b0;
        exp_main               = '0;
        g_cfg[0].bus.in_valid  = 1'b0;
        g_cfg[0].bus.x         = '0;
        g_cfg[0].bus.y         = '0;
        g_cfg[0].bus.cin       = 1'b0;
        g_cfg[0].bus.sub       = 1'b0;
        g_cfg[0].bus.out_ready = 1'b1;

        tab[0]  = '{16'h0008, 16'h0007, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0};
        tab[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tab[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tab[3]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
        tab[4]  = '{16'h000B, 16'h0005, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0};
        tab[5]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tab[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tab[7]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tab[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tab[9]  = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tab[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tab[11] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tab[12] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        #1;
        chk(0, "rst_out_valid", 64'(g_cfg[0].bus.out_valid), 64'(0));
        chk(0, "rst_sum", 64'(g_cfg[0].bus.sum), 64'(0));
        chk(0, "rst_cout", 64'(g_cfg[0].bus.cout), 64'(0));
        chk(0, "rst_ovf", 64'(g_cfg[0].bus.ovf), 64'(0));
        chk(0, "rst_in_ready", 64'(g_cfg[0].bus.in_ready), 64'(1));
        #2 rst_n = 1'b1;

        for (int i = 0; i < NTAB; i++) begin
            send(tab[i].x, tab[i].y, tab[i].cin, tab[i].sub, {tab[i].o, tab[i].c, 16'h0, tab[i].s});
        end
        drain();

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(16'(16'h1357 * (i + 1)), 16'(i * 3), 1'b0, 1'(i % 2),
                         m16(16'(16'h1357 * (i + 1)), 16'(i * 3), 1'b0, 1'(i % 2)));
                end
            end
            begin
                repeat (5) @(negedge clk);
                g_cfg[0].bus.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                g_cfg[0].bus.out_ready = 1'b1;
            end
        join
        drain();

        send(16'h0101, 16'h0202, 1'b0, 1'b0, m16(16'h0101, 16'h0202, 1'b0, 1'b0));
        send(16'h0303, 16'h0404, 1'b1, 1'b0, m16(16'h0303, 16'h0404, 1'b1, 1'b0));
        send(16'h0505, 16'h0606, 1'b0, 1'b1, m16(16'h0505, 16'h0606, 1'b0, 1'b1));
        idle();
        @(posedge clk);
        #1;
        chk(0, "pre_reset_valid", 64'(g_cfg[0].bus.out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk(0, "async_rst_valid", 64'(g_cfg[0].bus.out_valid), 64'(0));
        chk(0, "async_rst_sum", 64'(g_cfg[0].bus.sum), 64'(0));
        chk(0, "async_rst_cout", 64'(g_cfg[0].bus.cout), 64'(0));
        chk(0, "async_rst_ovf", 64'(g_cfg[0].bus.ovf), 64'(0));
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk(0, "post_reset_idle", 64'(g_cfg[0].bus.out_valid), 64'(0));
        end
        send(16'h4000, 16'h4000, 1'b0, 1'b0, m16(16'h4000, 16'h4000, 1'b0, 1'b0));
        drain();

        sweep_go = 1'b1;
        for (int t = 0; t < 30000 && n_done < NCFG - 1; t++) @(negedge clk);
        chk(0, "sweep_done", 64'(n_done), 64'(NCFG - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised N-bit add/subtract unit that carries the ripple-carry adder forward. The operand width is split into STAGES equal slices. Each slice is added in its own clock stage, and the inter-slice carry is registered. A valid/ready handshake on each side gives one result per cycle with backpressure. The block serves as the datapath adder for the arithmetic units and as a drop-in replacement wherever a wide ripple adder misses timing.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of STAGES
STAGES, 4, number of pipeline stages (1..WIDTH); slice width SW = WIDTH/STAGES

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set on x/y/cin/sub is valid
in_ready  output  1  block accepts operands this cycle
x  input  WIDTH  operand A (unsigned or two's complement)
y  input  WIDTH  operand B
cin  input  1  carry-in, add mode only
sub  input  1  0 = add, 1 = subtract (x - y)
out_valid  output  1  result on sum/cout/ovf is valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out; in subtract mode 1 = no borrow (x >= y unsigned)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, slice registers, carries, sum, cout and ovf go to 0; out_valid = 0.
- Reset mid-operation discards all in-flight operations. After release, the first accepted operand appears exactly STAGES cycles after its acceptance.
- Global advance enable: en = !out_valid || out_ready. in_ready = en, a combinational function of out_valid and out_ready.
- Transfer in: occurs on a clock edge with in_valid && in_ready. Transfer out: occurs on a clock edge with out_valid && out_ready.
- When en = 0, every pipeline register holds (stall). No operation is dropped or duplicated.
- When en = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0 and shifts through.
- Effective operand: ye = sub ? ~y : y. Effective carry-in: c0 = sub ? 1 : cin. cin is ignored when sub = 1.
- Stage k (k = 0..STAGES-1) computes slice bits [k*SW +: SW] = x_slice + ye_slice + carry_k.
  - carry_0 = c0.
  - carry_{k+1} is registered into stage k+1 along with that operation's remaining upper operand slices.
  - Completed lower result slices are carried forward, delay-matched.
- Latency: exactly STAGES cycles from accept to out_valid when not stalled. Throughput is 1 operation per cycle. STAGES = 1 degenerates to a single registered full-width adder.
- cout = carry out of the MSB slice. ovf = (x[MSB] == ye[MSB]) && (sum[MSB] != x[MSB]). Both are registered with sum and valid together with it.
- Arithmetic is modulo 2^WIDTH; sum wraps (e.g. all-ones + 1 = 0 with cout = 1).
- Operands, sub and cin are sampled only at acceptance. Changing them while in_ready = 0 has no effect.
- out_valid rises and falls only on clock edges. While out_valid = 1 and out_ready = 0, sum/cout/ovf are held stable.
- Simultaneous input transfer and output transfer in the same cycle is legal and sustains full throughput.
- Outputs when out_valid = 0 are don't-care after the first operation, but are 0 after reset.
- Illegal parameterisation (WIDTH % STAGES != 0) must stop elaboration via an assertion.

Test Plan:
1. WIDTH=16, STAGES=4, out_ready=1. Accept x=0x0008, y=0x0007, cin=0, sub=0 at cycle 0 -> at cycle 4 out_valid=1, sum=0x000F, cout=0, ovf=0.
2. Back-to-back adds: 0xFFFF+0x0001, then 0x7FFF+0x0001, then 0x00FF+0x0001 with cin=1 on consecutive cycles. Required results in order:
   - sum=0x0000, cout=1, ovf=0.
   - sum=0x8000, cout=0, ovf=1.
   - sum=0x0101, cout=0, ovf=0.
   - Results arrive on 3 consecutive cycles.
3. Subtract: x=0x000B, y=0x0005, sub=1, cin=1 -> sum=0x0006, cout=1. Then x=0x0003, y=0x0005, sub=1 -> sum=0xFFFE, cout=0. Then x=0x8000, y=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
4. Backpressure: stream 6 sequential operands with out_ready held 0 for cycles 5-9.
   - in_ready = 0 exactly while out_valid && !out_ready.
   - sum is held stable during the stall.
   - All 6 results appear in order with none lost or duplicated.
5. Reset mid-stream: 3 operands in flight, pulse rst_n low asynchronously between edges.
   - out_valid, sum, cout and ovf go to 0 immediately.
   - No stale result ever appears after release.
   - A new operand accepted post-release emerges after 4 cycles.
6. Parameter sweep (WIDTH,STAGES) = (4,1), (8,2), (32,8), (32,32) with 1000 random operands, random sub/cin and random out_ready -> every result matches a reference model for sum/cout/ovf, with latency = STAGES when not stalled.
